mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS datapath. Sequences fetch, decode, execute, memory and writeback around the
//  instruction decoder, whose fields (op, func) arrive here after decode_delay.
//  Drives all datapath mux/enable strobes, handshakes with instruction/data memory, flags illegal ops and memory
//  timeouts, and counts retired instructions.
// PARAMETERS
//  DECODE_WAIT  1    cycles held in DECODE so decoder outputs settle (>=1)
//  MEM_TIMEOUT  16   max consecutive cycles waiting on mem_ready_in before ERROR (>=1)
//  CNT_W        32   width of retired-instruction counter
// PORTS
//  clk            in   1      single clock, rising edge
//  reset_n        in   1      asynchronous active-low reset
//  op_in          in   6      opcode from decoder
//  func_in        in   6      R-type func from decoder
//  zero_in        in   1      ALU zero flag
//  mem_ready_in   in   1      memory completes current read/write this cycle
//  pc_write       out  1      PC load enable
//  pc_source      out  2      00 ALU result, 01 ALUOut (branch target), 10 jump target
//  ir_write       out  1      instruction register load
//  iord           out  1      0 address=PC, 1 address=ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  reg_write      out  1      register file write enable
//  reg_dst        out  1      1 rd, 0 rt
//  mem_to_reg     out  1      1 MDR, 0 ALUOut
//  alu_src_a      out  1      0 PC, 1 rs
//  alu_src_b      out  2      00 rt, 01 const 4, 10 extended imm16, 11 imm16<<2 sign-ext
//  ext_zero       out  1      1 zero-extend imm16 (andi/ori), else sign-extend
//  alu_ctrl       out  4      0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
//  state_out      out  3      current state code
//  err_out        out  1      sticky error flag
//  err_code       out  2      01 illegal op/func, 10 memory timeout
//  retire_count   out  CNT_W  instructions retired, wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: INIT=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERROR=7. reset_n low -> INIT; counters, err, retire_count = 0.
//  All strobe outputs are combinational from state/op/func/zero_in/mem_ready_in; unlisted strobes = 0.
//  INIT: all strobes 0; next cycle FETCH.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add.
//   If mem_ready_in=1: ir_write=1, pc_write=1, pc_source=00 -> DECODE.
//  DECODE: held DECODE_WAIT cycles; alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target to ALUOut).
//   On final cycle, decode op_in.
//   Legal ops: 0x00 R (func 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), 0x23 lw, 0x2B sw, 0x04 beq,
//   0x05 bne, 0x08 addi, 0x0C andi, 0x0D ori, 0x02 j.
//   j: pc_write=1, pc_source=10, retire -> FETCH. Other legal -> EXEC. Illegal op/func -> ERROR, err_code=01.
//  EXEC:
//   R: alu_src_a=1, alu_src_b=00, alu_ctrl per func -> WB.
//   lw/sw/addi: alu_src_a=1, alu_src_b=10, add; lw/sw -> MEM, addi -> WB.
//   andi/ori: alu_src_b=10, ext_zero=1, and/or -> WB.
//   beq/bne: alu_src_a=1, alu_src_b=00, sub, pc_source=01, pc_write = zero_in (beq) / !zero_in (bne);
//   retire -> FETCH.
//  MEM: iord=1; lw mem_read=1, sw mem_write=1. On mem_ready_in: lw -> WB; sw retire -> FETCH.
//  WB: reg_write=1; reg_dst=1 for R only; mem_to_reg=1 for lw only; retire -> FETCH.
//  Timeout: wait counter clears on entry to FETCH/MEM and counts cycles with mem_ready_in=0.
//   Reaching MEM_TIMEOUT -> ERROR, err_code=10. mem_ready_in on the same cycle as the limit wins (no error).
//  ERROR: all strobes 0, err_out=1, FSM frozen; exit only via reset_n.
//  Retire: retire_count increments by 1 on the cycle the FSM leaves an instruction's last state for FETCH;
//   wraps all-ones -> 0.
//  Reset mid-instruction: immediate return to INIT; no partial pc_write/reg_write/mem_write after assertion.
// TESTING
//  add (op 00, func 20), mem_ready_in=1 -> INIT,FETCH,DECODE,EXEC,WB,FETCH; reg_write+reg_dst in WB; retire_count=1.
//  lw with mem_ready_in low 3 cycles in MEM -> MEM held 4 cycles, mem_read+iord=1, then WB mem_to_reg=1.
//  beq zero_in=1 -> pc_write=1, pc_source=01 in EXEC; zero_in=0 -> pc_write=0; bne inverse.
//  op 0x3F -> ERROR after DECODE, err_out=1, err_code=01, state_out=7 persists until reset_n.
//  mem_ready_in held 0 in FETCH, MEM_TIMEOUT=4 -> ERROR on 4th wait cycle, err_code=10.
//  CNT_W=4, retire 17 j instructions -> retire_count=1; reset_n low mid-EXEC -> state_out=0, all strobes 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Multi-cycle MIPS control FSM. Sequences fetch, decode,
//                execute, memory and writeback around the instruction
//                decoder. Drives every datapath mux/enable strobe,
//                handshakes with memory, flags illegal instructions and
//                memory timeouts, and counts retired instructions.
//  Ports       : clk, reset_n (async, active low)
//                op_in/func_in   decoded opcode / R-type func
//                zero_in         ALU zero flag
//                mem_ready_in    memory completes current access this cycle
//                pc_write..alu_ctrl  datapath strobes (combinational)
//                state_out       current state code
//                err_out/err_code sticky error flag and cause
//                retire_count    retired instructions, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int DECODE_WAIT = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op_in,
    input  logic [5:0]       func_in,
    input  logic             zero_in,
    input  logic             mem_ready_in,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_zero,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       state_out,
    output logic             err_out,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retire_count
);

    // State encoding
    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    // Opcodes
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // R-type func codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operations
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Error causes
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Counter widths sized so the last legal value fits
    localparam int DEC_W  = (DECODE_WAIT > 1) ? $clog2(DECODE_WAIT) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECODE_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        state_q,  state_d;
    logic [DEC_W-1:0]  dec_q,    dec_d;
    logic [WAIT_W-1:0] wait_q,   wait_d;
    logic              err_q,    err_d;
    logic [1:0]        code_q,   code_d;
    logic [CNT_W-1:0]  retire_q, retire_d;

    logic       w_retire;
    logic       w_dec_last;
    logic       w_func_legal;
    logic       w_op_legal;
    logic [3:0] w_r_alu;

    assign w_dec_last = (dec_q == DEC_LAST);

    // Instruction classification
    always_comb begin
        w_func_legal = 1'b1;
        w_r_alu      = ALU_ADD;
        case (func_in)
            FN_ADD:  w_r_alu = ALU_ADD;
            FN_SUB:  w_r_alu = ALU_SUB;
            FN_AND:  w_r_alu = ALU_AND;
            FN_OR:   w_r_alu = ALU_OR;
            FN_SLT:  w_r_alu = ALU_SLT;
            default: w_func_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_op_legal = 1'b1;
        case (op_in)
            OP_R:                          w_op_legal = w_func_legal;
            OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: w_op_legal = 1'b1;
            default:                       w_op_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            dec_q    <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            code_q   <= code_d;
            retire_q <= retire_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        dec_d    = '0;
        wait_d   = wait_q;
        err_d    = err_q;
        code_d   = code_q;
        w_retire = 1'b0;

        case (state_q)
            ST_INIT: state_d = ST_FETCH;

            ST_FETCH: begin
                // A ready on the limit cycle completes normally
                if (mem_ready_in) begin
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_DECODE: begin
                if (!w_dec_last) begin
                    dec_d = dec_q + DEC_W'(1);
                end else if (!w_op_legal) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    code_d  = ERR_ILLEGAL;
                end else if (op_in == OP_J) begin
                    state_d  = ST_FETCH;
                    w_retire = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (op_in == OP_BEQ || op_in == OP_BNE) begin
                    state_d  = ST_FETCH;
                    w_retire = 1'b1;
                end else if (op_in == OP_LW || op_in == OP_SW) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_MEM: begin
                if (mem_ready_in) begin
                    if (op_in == OP_LW) begin
                        state_d = ST_WB;
                    end else begin
                        state_d  = ST_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_WB: begin
                state_d  = ST_FETCH;
                w_retire = 1'b1;
            end

            ST_ERROR: state_d = ST_ERROR;

            default: state_d = ST_INIT;
        endcase

        // Every state change restarts the memory wait count, so FETCH and
        // MEM always begin counting from zero.
        if (state_d != state_q) begin
            wait_d = '0;
        end

        retire_d = w_retire ? retire_q + CNT_W'(1) : retire_q;
    end

    // Output logic
    always_comb begin
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        alu_ctrl   = 4'b0000;

        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (mem_ready_in) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end

            ST_DECODE: begin
                // Branch target is computed speculatively into ALUOut
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                if (w_dec_last && op_in == OP_J) begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
            end

            ST_EXEC: begin
                alu_src_a = 1'b1;
                case (op_in)
                    OP_R: begin
                        alu_ctrl = w_r_alu;
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        alu_src_b = 2'b10;
                        alu_ctrl  = ALU_ADD;
                    end
                    OP_ANDI, OP_ORI: begin
                        alu_src_b = 2'b10;
                        ext_zero  = 1'b1;
                        alu_ctrl  = (op_in == OP_ANDI) ? ALU_AND : ALU_OR;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_ctrl  = ALU_SUB;
                        pc_source = 2'b01;
                        pc_write  = (op_in == OP_BEQ) ? zero_in : !zero_in;
                    end
                    default: alu_src_a = 1'b0;
                endcase
            end

            ST_MEM: begin
                iord      = 1'b1;
                mem_read  = (op_in == OP_LW);
                mem_write = (op_in == OP_SW);
            end

            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_in == OP_R);
                mem_to_reg = (op_in == OP_LW);
            end

            default: ;
        endcase
    end

    assign state_out    = state_q;
    assign err_out      = err_q;
    assign err_code     = code_q;
    assign retire_count = retire_q;

endmodule
`default_nettype wire
